// File: rtl/user_pulser_sequencer.sv
// Timed command scheduler: queued {delay, start, stop} commands are replayed as one-cycle strobes.
// Define USER_PULSER_SEQ_WAIT_READY_EN to add a per-command hold until the targeted pulsers are ready.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// IDLE      | no command in flight; pops when enabled and the queue is non-empty
// DELAY     | down-counting the command delay to zero
// WAIT_RDY  | holding the fire until targeted pulsers report ready (macro only)
// FIRE      | strobes driven this cycle; chains straight into the next command
module user_pulser_sequencer #(
    parameter int N_PULSER_INST = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int DELAY_WIDTH   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          flush_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [DELAY_WIDTH-1:0]        cmd_delay_i,
    input  logic [N_PULSER_INST-1:0]      cmd_start_i,
    input  logic [N_PULSER_INST-1:0]      cmd_stop_i,
    input  logic                          cmd_wait_rdy_i,
    input  logic [N_PULSER_INST-1:0]      pulser_ready_i,
    output logic [N_PULSER_INST-1:0]      start_o,
    output logic [N_PULSER_INST-1:0]      stop_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef USER_PULSER_SEQ_WAIT_READY_EN
    localparam int SB = 1;
`else
    localparam int SB = 0;
`endif
    // Entry layout, MSB first: {delay, start mask, stop mask, [wait_rdy]}
    localparam int EW = DELAY_WIDTH + 2 * N_PULSER_INST + SB;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DELAY    = 2'd1,
        ST_FIRE     = 2'd2
`ifdef USER_PULSER_SEQ_WAIT_READY_EN
        ,
        ST_WAIT_RDY = 2'd3
`endif
    } state_t;

    state_t                    state_q, state_d;
    logic [EW-1:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]             level_q, level_d;
    logic [DELAY_WIDTH-1:0]    cnt_q, cnt_d;
    logic [N_PULSER_INST-1:0]  start_q, start_d;
    logic [N_PULSER_INST-1:0]  stop_q, stop_d;
    logic [EW-1:0]             wr_entry;
    logic [EW-1:0]             rd_entry;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;

`ifdef USER_PULSER_SEQ_WAIT_READY_EN
    logic                      wrdy_q, wrdy_d;
    assign wr_entry = {cmd_delay_i, cmd_start_i, cmd_stop_i, cmd_wait_rdy_i};
`else
    logic                      unused_inputs;
    assign wr_entry      = {cmd_delay_i, cmd_start_i, cmd_stop_i};
    assign unused_inputs = ^{cmd_wait_rdy_i, pulser_ready_i};
`endif

    assign rd_entry = mem_q[rd_ptr_q];
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign empty    = (level_q == '0);

    // A pop in the same cycle frees a slot, so a full queue still accepts the push.
    assign pop         = !flush_i && enable_i && !empty &&
                         ((state_q == ST_IDLE) || (state_q == ST_FIRE));
    assign cmd_ready_o = (!full || pop) && !flush_i;
    assign push        = cmd_valid_i && cmd_ready_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        stop_d  = stop_q;
`ifdef USER_PULSER_SEQ_WAIT_READY_EN
        wrdy_d  = wrdy_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_FIRE;
`ifdef USER_PULSER_SEQ_WAIT_READY_EN
                    if (wrdy_q) state_d = ST_WAIT_RDY;
`endif
                end
            end
`ifdef USER_PULSER_SEQ_WAIT_READY_EN
            ST_WAIT_RDY: begin
                if (((start_q | stop_q) & ~pulser_ready_i) == '0) state_d = ST_FIRE;
            end
`endif
            ST_FIRE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            state_d = ST_DELAY;
            cnt_d   = rd_entry[SB + 2 * N_PULSER_INST +: DELAY_WIDTH];
            start_d = rd_entry[SB + N_PULSER_INST +: N_PULSER_INST];
            stop_d  = rd_entry[SB +: N_PULSER_INST];
`ifdef USER_PULSER_SEQ_WAIT_READY_EN
            wrdy_d  = rd_entry[0];
`endif
        end
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            start_q  <= '0;
            stop_q   <= '0;
`ifdef USER_PULSER_SEQ_WAIT_READY_EN
            wrdy_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
`ifdef USER_PULSER_SEQ_WAIT_READY_EN
            wrdy_q   <= wrdy_d;
`endif
        end
    end

    // Queue storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    // Strobes are a decode of flopped state and working masks only; stop wins on overlap.
    assign start_o      = (state_q == ST_FIRE) ? (start_q & ~stop_q) : '0;
    assign stop_o       = (state_q == ST_FIRE) ? stop_q : '0;
    assign done_o       = (state_q == ST_FIRE) && empty;
    assign busy_o       = (state_q != ST_IDLE);
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_user_pulser_sequencer.sv
// Scoreboard bench for user_pulser_sequencer: expected strobe events are queued as stimulus is
// issued; a negedge monitor pops and compares whenever any strobe or done_o is seen.
module tb_user_pulser_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_delay;
    logic [3:0]  cmd_start;
    logic [3:0]  cmd_stop;
    logic        cmd_wait_rdy;
    logic [3:0]  pulser_ready;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic        busy;
    logic        done;
    logic [3:0]  level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic [3:0] sp;
        logic       dn;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    user_pulser_sequencer #(
        .N_PULSER_INST(4),
        .FIFO_DEPTH(8),
        .DELAY_WIDTH(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(enable),
        .flush_i(flush),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_delay_i(cmd_delay),
        .cmd_start_i(cmd_start),
        .cmd_stop_i(cmd_stop),
        .cmd_wait_rdy_i(cmd_wait_rdy),
        .pulser_ready_i(pulser_ready),
        .start_o(start),
        .stop_o(stop),
        .busy_o(busy),
        .done_o(done),
        .fifo_level_o(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push(input int d, input logic [3:0] st, input logic [3:0] sp,
                        input logic wr, output int p);
        @(negedge clk);
        p            = cyc;
        cmd_delay    = 16'(d);
        cmd_start    = st;
        cmd_stop     = sp;
        cmd_wait_rdy = wr;
        cmd_valid    = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (start != 4'b0 || stop != 4'b0 || done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: cycle %0d start=%b stop=%b done=%b, none expected",
                         cyc, start, stop, done);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_cycle", cyc, mon_e.cyc);
                chk("strobe_start", start, mon_e.st);
                chk("strobe_stop", stop, mon_e.sp);
                chk("strobe_done", done, mon_e.dn);
            end
        end
    end

    initial begin
        int p;
        int p0;
        int q;
        int r;
        int dummy;

        rst          = 1'b1;
        enable       = 1'b0;
        flush        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_delay    = '0;
        cmd_start    = '0;
        cmd_stop     = '0;
        cmd_wait_rdy = 1'b0;
        pulser_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_start", start, 0);
        chk("rst_stop", stop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_level", level, 0);
        rst    = 1'b0;
        enable = 1'b1;

        // Single command: fire p+D+3
        push(5, 4'b0001, 4'b0000, 1'b0, p);
        exp_q.push_back('{p + 8, 4'b0001, 4'b0000, 1'b1});
        @(negedge clk);
        chk("single_level_after_push", level, 1);
        chk("single_busy_before_pop", busy, 0);
        @(negedge clk);
        chk("single_busy_in_delay", busy, 1);
        repeat (10) @(negedge clk);

        // Back-to-back: spacing D_next+2, done only on last
        push(0, 4'b0001, 4'b0000, 1'b0, p0);
        exp_q.push_back('{p0 + 3, 4'b0001, 4'b0000, 1'b0});
        exp_q.push_back('{p0 + 8, 4'b0010, 4'b0000, 1'b0});
        exp_q.push_back('{p0 + 20, 4'b0100, 4'b0000, 1'b1});
        push(3, 4'b0010, 4'b0000, 1'b0, dummy);
        push(10, 4'b0100, 4'b0000, 1'b0, dummy);
        repeat (25) @(negedge clk);

        // Overlapping start/stop: stop wins
        push(2, 4'b1111, 4'b0101, 1'b0, p);
        exp_q.push_back('{p + 5, 4'b1010, 4'b0101, 1'b1});
        repeat (8) @(negedge clk);

        // enable drop mid-command: in-flight fires without done, next waits for re-enable
        push(4, 4'b0001, 4'b0000, 1'b0, p);
        exp_q.push_back('{p + 7, 4'b0001, 4'b0000, 1'b0});
        push(0, 4'b1000, 4'b0000, 1'b0, dummy);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        chk("endrop_busy_idle", busy, 0);
        chk("endrop_level", level, 1);
        enable = 1'b1;
        exp_q.push_back('{cyc + 2, 4'b1000, 4'b0000, 1'b1});
        repeat (5) @(negedge clk);

        // Fill queue while disabled, then simultaneous push+pop at full
        enable = 1'b0;
        for (int i = 1; i <= 8; i++) push(1, 4'(i), 4'b0000, 1'b0, dummy);
        @(negedge clk);
        chk("full_ready_low", cmd_ready, 0);
        chk("full_level", level, 8);
        q            = cyc;
        cmd_delay    = 16'd1;
        cmd_start    = 4'd9;
        cmd_stop     = 4'b0000;
        cmd_wait_rdy = 1'b0;
        cmd_valid    = 1'b1;
        enable       = 1'b1;
        #1;
        chk("full_ready_with_pop", cmd_ready, 1);
        for (int k = 0; k <= 8; k++)
            exp_q.push_back('{q + 3 + 3 * k, 4'(k + 1), 4'b0000, (k == 8)});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("full_level_push_pop", level, 8);
        repeat (35) @(negedge clk);

        // Flush mid-delay with 3 queued entries
        push(100, 4'b0001, 4'b0000, 1'b0, p);
        for (int i = 0; i < 3; i++) push(0, 4'b0010, 4'b0000, 1'b0, dummy);
        repeat (5) @(negedge clk);
        chk("flush_pre_level", level, 3);
        chk("flush_pre_busy", busy, 1);
        flush = 1'b1;
        #1;
        chk("flush_ready_low", cmd_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_level", level, 0);
        chk("flush_ready", cmd_ready, 1);
        repeat (110) @(negedge clk);

        // Reset mid-delay discards the command
        push(3, 4'b0001, 4'b0000, 1'b0, p);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_level", level, 0);
        chk("midrst_ready", cmd_ready, 1);
        repeat (8) @(negedge clk);

`ifdef USER_PULSER_SEQ_WAIT_READY_EN
        pulser_ready = 4'b0000;
        push(0, 4'b0000, 4'b0010, 1'b1, p);
        repeat (20) @(negedge clk);
        chk("wait_rdy_busy", busy, 1);
        pulser_ready = 4'b0010;
        r = cyc;
        exp_q.push_back('{r + 1, 4'b0000, 4'b0010, 1'b1});
        repeat (5) @(negedge clk);
`else
        // Without the feature, wait_rdy and pulser_ready are ignored
        pulser_ready = 4'b0000;
        push(0, 4'b0000, 4'b0010, 1'b1, p);
        exp_q.push_back('{p + 3, 4'b0000, 4'b0010, 1'b1});
        repeat (6) @(negedge clk);
        r = p;
        chk("no_wait_rdy_busy", busy, 0);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
